// File: rtl/stack_sequencer.sv
// stack_sequencer: PUSH/POP/CALL/RET data-memory sequencer; define STACK_GUARD_EN for overflow/underflow checks
module stack_sequencer #(
  parameter logic [7:0] STACK_TOP   = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op_code,
  input  logic [1:0] op_reg,
  input  logic [7:0] push_data,
  input  logic [7:0] ret_addr,
  input  logic [7:0] call_target,
  input  logic [7:0] sp_value,
  output logic       stack_push,
  output logic       stack_pop,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       rf_write_en,
  output logic [1:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic       pc_load,
  output logic [7:0] pc_next,
  output logic       done,
  output logic       err_ovf,
  output logic       err_unf
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, DONE} state_t;
  state_t     r_state;
  logic [1:0] r_op, r_reg;
  logic [7:0] r_data, r_tgt, r_res;
  logic       r_fail;
  logic       w_ovf, w_unf, w_wr, w_rd, w_done;
`ifdef STACK_GUARD_EN
  logic r_ovf, r_unf;
  assign w_ovf   = sp_value == STACK_LIMIT;
  assign w_unf   = sp_value == STACK_TOP;
  assign err_ovf = r_ovf;
  assign err_unf = r_unf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (r_state == WRITE && w_ovf) r_ovf <= 1'b1;
      if (r_state == READ && w_unf) r_unf <= 1'b1;
    end
  end
`else
  assign w_ovf   = 1'b0;
  assign w_unf   = 1'b0;
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= 2'd0;
      r_reg   <= 2'd0;
      r_data  <= 8'h00;
      r_tgt   <= 8'h00;
      r_res   <= 8'h00;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (op_valid) begin
          r_op    <= op_code;
          r_reg   <= op_reg;
          r_data  <= (op_code == 2'd2) ? ret_addr : push_data;
          r_tgt   <= call_target;
          r_fail  <= 1'b0;
          r_state <= op_code[0] ? READ : WRITE;
        end
        WRITE: begin
          r_fail  <= w_ovf;
          r_state <= DONE;
        end
        READ: begin
          r_fail  <= w_unf;
          r_state <= w_unf ? DONE : CAPTURE;
        end
        CAPTURE: begin
          r_res   <= mem_rdata;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // strobes are masked by rst so an aborted operation never touches memory or SP
  assign w_wr   = !rst && r_state == WRITE && !w_ovf;
  assign w_rd   = !rst && r_state == READ && !w_unf;
  assign w_done = !rst && r_state == DONE;
  assign op_ready      = r_state == IDLE;
  assign stack_push    = w_wr;
  assign stack_pop     = w_rd;
  assign mem_we        = w_wr;
  assign mem_re        = w_rd;
  assign mem_addr      = w_wr ? sp_value : w_rd ? sp_value + 8'd1 : 8'h00;
  assign mem_wdata     = w_wr ? r_data : 8'h00;
  assign done          = w_done;
  assign rf_write_en   = w_done && r_op == 2'd1 && !r_fail;
  assign rf_write_addr = rf_write_en ? r_reg : 2'd0;
  assign rf_write_data = rf_write_en ? r_res : 8'h00;
  assign pc_load       = w_done && r_op[1] && !r_fail;
  assign pc_next       = !pc_load ? 8'h00 : r_op[0] ? r_res : r_tgt;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: scoreboard bench with register-file SP and data-memory models
module tb_stack_sequencer;
  logic       clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
  logic [1:0] op_code = 2'd0, op_reg = 2'd0;
  logic [7:0] push_data = 8'h00, ret_addr = 8'h00, call_target = 8'h00;
  logic [7:0] sp_value, mem_rdata = 8'h00;
  logic       op_ready, stack_push, stack_pop, mem_we, mem_re, rf_write_en, pc_load, done, err_ovf, err_unf;
  logic [7:0] mem_addr, mem_wdata, rf_write_data, pc_next;
  logic [1:0] rf_write_addr;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] sp = 8'hFF;
  typedef struct packed {logic en; logic [1:0] ra; logic [7:0] rd; logic pl; logic [7:0] pn;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_reg(op_reg),
    .push_data(push_data), .ret_addr(ret_addr), .call_target(call_target), .sp_value(sp_value),
    .stack_push(stack_push), .stack_pop(stack_pop), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .pc_load(pc_load), .pc_next(pc_next),
    .done(done), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;
  assign sp_value = sp;

  // register file SP (R3) and data memory environment
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (rf_write_en && rf_write_addr == 2'd3) sp <= rf_write_data;
    else if (stack_push) sp <= sp - 8'd1;
    else if (stack_pop) sp <= sp + 8'd1;
  end

  always @(negedge clk) begin
    if (stack_push || stack_pop) begin
      tests++;
      if (stack_push && stack_pop) begin
        fails++;
        $display("FAIL push_pop_exclusive push=%b pop=%b required one of them", stack_push, stack_pop);
      end
    end
    if (done) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected done=1 with no operation outstanding");
      end else begin
        e = q.pop_front();
        if ({rf_write_en, rf_write_addr, rf_write_data, pc_load, pc_next} !== e) begin
          fails++;
          $display("FAIL done_result rf_en=%b ra=%0d rd=%h pl=%b pn=%h required rf_en=%b ra=%0d rd=%h pl=%b pn=%h",
                   rf_write_en, rf_write_addr, rf_write_data, pc_load, pc_next, e.en, e.ra, e.rd, e.pl, e.pn);
        end
      end
    end
  end

  function automatic exp_t ex(input logic en, input logic [1:0] ra, input logic [7:0] rd, input logic pl, input logic [7:0] pn);
    return {en, ra, rd, pl, pn};
  endfunction

  task automatic start(input logic [1:0] c, input logic [1:0] r, input logic [7:0] d, input logic [7:0] ra, input logic [7:0] ct);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL start_timeout op_ready=%b required 1", op_ready); end
    op_valid = 1'b1; op_code = c; op_reg = r; push_data = d; ret_addr = ra; call_target = ct;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL idle_timeout op_ready=%b required 1", op_ready); end
  endtask

  task automatic set_sp(input logic [7:0] v);
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd0, 2'd0, v, 8'h00, 8'h00);
    wait_idle;
    q.push_back(ex(1'b1, 2'd3, v, 1'b0, 8'h00));
    start(2'd1, 2'd3, 8'h00, 8'h00, 8'h00);
    wait_idle;
    tests++;
    if (sp !== v) begin fails++; $display("FAIL pop_into_sp sp=%h required %h", sp, v); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({stack_push, stack_pop, mem_we, mem_re, rf_write_en, pc_load, done} !== 7'b0) begin
      fails++; $display("FAIL reset_strobes_in_reset got %b required 0000000", {stack_push, stack_pop, mem_we, mem_re, rf_write_en, pc_load, done});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({op_ready, stack_push, stack_pop, mem_we, mem_re, rf_write_en, pc_load, done} !== 8'b1000_0000) begin
      fails++; $display("FAIL reset_strobes got %b required 10000000", {op_ready, stack_push, stack_pop, mem_we, mem_re, rf_write_en, pc_load, done});
    end
    tests++;
    if ({mem_addr, mem_wdata, rf_write_addr, rf_write_data, pc_next} !== 34'd0) begin
      fails++; $display("FAIL reset_data addr=%h wdata=%h ra=%0d rd=%h pn=%h required all 0", mem_addr, mem_wdata, rf_write_addr, rf_write_data, pc_next);
    end
    tests++;
    if ({err_ovf, err_unf} !== 2'b00) begin fails++; $display("FAIL reset_err got %b required 00", {err_ovf, err_unf}); end
  endtask

  task automatic test_push;
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd0, 2'd0, 8'h5A, 8'h00, 8'h00);
    @(negedge clk);
    tests++;
    if ({mem_we, stack_push, stack_pop, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b0, 8'hFF, 8'h5A}) begin
      fails++; $display("FAIL push_write we=%b push=%b pop=%b addr=%h wdata=%h required 1 1 0 ff 5a", mem_we, stack_push, stack_pop, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if ({done, sp_value} !== {1'b1, 8'hFE}) begin fails++; $display("FAIL push_done done=%b sp=%h required 1 fe", done, sp_value); end
    tests++;
    if (mem[8'hFF] !== 8'h5A) begin fails++; $display("FAIL push_mem mem[ff]=%h required 5a", mem[8'hFF]); end
    @(negedge clk);
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL push_ready op_ready=%b required 1", op_ready); end
  endtask

  task automatic test_pop;
    q.push_back(ex(1'b1, 2'd1, 8'h5A, 1'b0, 8'h00));
    start(2'd1, 2'd1, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    tests++;
    if ({mem_re, mem_we, stack_pop, stack_push, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'hFF}) begin
      fails++; $display("FAIL pop_read re=%b we=%b pop=%b push=%b addr=%h required 1 0 1 0 ff", mem_re, mem_we, stack_pop, stack_push, mem_addr);
    end
    @(negedge clk);
    tests++;
    if ({done, op_ready} !== 2'b00) begin fails++; $display("FAIL pop_capture done=%b ready=%b required 0 0", done, op_ready); end
    @(negedge clk);
    tests++;
    if ({done, sp_value} !== {1'b1, 8'hFF}) begin fails++; $display("FAIL pop_done done=%b sp=%h required 1 ff", done, sp_value); end
    @(negedge clk);
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL pop_ready op_ready=%b required 1", op_ready); end
  endtask

  task automatic test_call_ret;
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b1, 8'h40));
    start(2'd2, 2'd0, 8'h00, 8'h21, 8'h40);
    @(negedge clk);
    tests++;
    if ({mem_we, stack_push, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'hFF, 8'h21}) begin
      fails++; $display("FAIL call_write we=%b push=%b addr=%h wdata=%h required 1 1 ff 21", mem_we, stack_push, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if ({done, pc_load} !== 2'b11) begin fails++; $display("FAIL call_done done=%b pc_load=%b required 1 1", done, pc_load); end
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b1, 8'h21));
    start(2'd3, 2'd0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    tests++;
    if ({done, pc_load, pc_next, sp_value} !== {1'b1, 1'b1, 8'h21, 8'hFF}) begin
      fails++; $display("FAIL ret_done done=%b pl=%b pn=%h sp=%h required 1 1 21 ff", done, pc_load, pc_next, sp_value);
    end
    wait_idle;
  endtask

  task automatic test_back_to_back;
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd0, 2'd0, 8'h77, 8'h00, 8'h00);
    wait_idle;
    q.push_back(ex(1'b1, 2'd2, 8'h77, 1'b0, 8'h00));
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    op_valid = 1'b1; op_code = 2'd1; op_reg = 2'd2;
    @(posedge clk);
    #1 op_code = 2'd0; push_data = 8'h11;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (op_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy cycle N+%0d op_ready=%b required 0", k, op_ready); end
    end
    @(negedge clk);
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready cycle N+4 op_ready=%b required 1", op_ready); end
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_we, mem_wdata} !== {1'b1, 8'h11}) begin fails++; $display("FAIL b2b_second we=%b wdata=%h required 1 11", mem_we, mem_wdata); end
    wait_idle;
  endtask

  task automatic test_reset_abort;
    logic [7:0] s0, m0;
    start(2'd0, 2'd0, 8'h99, 8'h00, 8'h00);
    rst = 1'b1;
    s0 = sp;
    m0 = mem[s0];
    @(negedge clk);
    tests++;
    if ({mem_we, stack_push} !== 2'b00) begin fails++; $display("FAIL abort_strobes we=%b push=%b required 0 0", mem_we, stack_push); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({op_ready, sp} !== {1'b1, s0}) begin fails++; $display("FAIL abort_state ready=%b sp=%h required 1 %h", op_ready, sp, s0); end
    tests++;
    if (mem[s0] !== m0) begin fails++; $display("FAIL abort_mem mem=%h required %h", mem[s0], m0); end
  endtask

`ifdef STACK_GUARD_EN
  task automatic test_guard;
    set_sp(8'hFF);
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd1, 2'd1, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    tests++;
    if ({mem_re, stack_pop} !== 2'b00) begin fails++; $display("FAIL unf_read re=%b pop=%b required 0 0", mem_re, stack_pop); end
    @(negedge clk);
    tests++;
    if ({done, rf_write_en} !== 2'b10) begin fails++; $display("FAIL unf_done done=%b rf_en=%b required 1 0", done, rf_write_en); end
    wait_idle;
    tests++;
    if ({err_unf, err_ovf, sp} !== {1'b1, 1'b0, 8'hFF}) begin fails++; $display("FAIL unf_flag unf=%b ovf=%b sp=%h required 1 0 ff", err_unf, err_ovf, sp); end
    set_sp(8'h80);
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd2, 2'd0, 8'h00, 8'h55, 8'h66);
    @(negedge clk);
    tests++;
    if ({mem_we, stack_push} !== 2'b00) begin fails++; $display("FAIL ovf_write we=%b push=%b required 0 0", mem_we, stack_push); end
    wait_idle;
    tests++;
    if ({err_ovf, err_unf, sp} !== {1'b1, 1'b1, 8'h80}) begin fails++; $display("FAIL ovf_flag ovf=%b unf=%b sp=%h required 1 1 80", err_ovf, err_unf, sp); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({err_ovf, err_unf} !== 2'b00) begin fails++; $display("FAIL err_clear got %b required 00", {err_ovf, err_unf}); end
  endtask
`else
  task automatic test_wrap;
    set_sp(8'h00);
    q.push_back(ex(1'b0, 2'd0, 8'h00, 1'b0, 8'h00));
    start(2'd0, 2'd0, 8'h33, 8'h00, 8'h00);
    @(negedge clk);
    tests++;
    if ({mem_we, stack_push, mem_addr} !== {1'b1, 1'b1, 8'h00}) begin fails++; $display("FAIL wrap_write we=%b push=%b addr=%h required 1 1 00", mem_we, stack_push, mem_addr); end
    wait_idle;
    tests++;
    if ({mem[8'h00], sp, err_ovf} !== {8'h33, 8'hFF, 1'b0}) begin fails++; $display("FAIL wrap_result mem0=%h sp=%h ovf=%b required 33 ff 0", mem[8'h00], sp, err_ovf); end
  endtask
`endif

  initial begin
    test_reset;
    test_push;
    test_pop;
    test_call_ret;
    test_back_to_back;
    test_reset_abort;
`ifdef STACK_GUARD_EN
    test_guard;
`else
    test_wrap;
`endif
    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL scoreboard_drain %0d completions missing required 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
